// File: rtl/lsu_pkg.sv
// Shared constants and legality helpers for the load/store memory controller.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] offset);
        case (f3)
            F3_H, F3_HU: return offset[0] == 1'b0;
            F3_W:        return offset == 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core request/response and data-memory port bundle for lsu_mem_ctrl.
interface lsu_mem_ctrl_if #(parameter int ADDR_W = 32);

    logic              Req;
    logic              Is_Store;
    logic [2:0]        Funct3;
    logic [ADDR_W-1:0] Addr;
    logic [31:0]       Store_Data;
    logic              Ready;
    logic              Done;
    logic              Error;
    logic [31:0]       Load_Data;
    logic [ADDR_W-1:0] Mem_Address;
    logic [31:0]       Mem_Write_Data;
    logic              Mem_WE;
    logic [31:0]       Mem_Read_Data;

    modport master (
        output Req, Is_Store, Funct3, Addr, Store_Data, Mem_Read_Data,
        input  Ready, Done, Error, Load_Data, Mem_Address, Mem_Write_Data, Mem_WE
    );

    modport slave (
        input  Req, Is_Store, Funct3, Addr, Store_Data, Mem_Read_Data,
        output Ready, Done, Error, Load_Data, Mem_Address, Mem_Write_Data, Mem_WE
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extraction/extension and sub-word store merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] load_word,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] load_result,
    output logic [31:0] merged
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = load_word[{offset, 3'b000} +: 8];
        lane_half = load_word[{offset[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    load_result = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_result = {24'h0, lane_byte};
            F3_H:    load_result = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_result = {16'h0, lane_half};
            default: load_result = load_word;
        endcase
    end

    always_comb begin
        merged = old_word;
        case (funct3)
            F3_B:    merged[{offset, 3'b000} +: 8]     = new_data[7:0];
            F3_H:    merged[{offset[1], 4'b0000} +: 16] = new_data[15:0];
            default: merged = new_data;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a word-wide memory without byte enables.
// Define LSU_PERF_CNT_EN to add the Load_Count/Store_Count outputs.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 512
) (
    input  logic Clk,
    input  logic Rst,
    lsu_mem_ctrl_if.slave bus
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0] Load_Count,
    output logic [31:0] Store_Count
`endif
);

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

    logic [1:0]        state;
    logic              is_store_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       sdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              legal;
    logic [31:0]       load_result;
    logic [31:0]       merged;

    always_comb begin
        legal = f3_legal(bus.Is_Store, bus.Funct3) &&
                is_aligned(bus.Funct3, bus.Addr[1:0]) &&
                (bus.Addr < MEM_LIMIT);
    end

    lsu_lane_align u_align (
        .load_word   (bus.Mem_Read_Data),
        .old_word    (rdata_q),
        .new_data    (sdata_q),
        .offset      (addr_q[1:0]),
        .funct3      (funct3_q),
        .load_result (load_result),
        .merged      (merged)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state         <= ST_IDLE;
            is_store_q    <= 1'b0;
            funct3_q      <= '0;
            addr_q        <= '0;
            sdata_q       <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            bus.Load_Data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.Req) begin
                        is_store_q <= bus.Is_Store;
                        funct3_q   <= bus.Funct3;
                        addr_q     <= bus.Addr;
                        sdata_q    <= bus.Store_Data;
                        err_q      <= !legal;
                        // Full-word stores need no read-back; sub-word stores merge.
                        if (!legal)
                            state <= ST_RESP;
                        else if (bus.Is_Store && bus.Funct3 == F3_W)
                            state <= ST_WR;
                        else
                            state <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (is_store_q) begin
                        rdata_q <= bus.Mem_Read_Data;
                        state   <= ST_WR;
                    end else begin
                        bus.Load_Data <= load_result;
                        state         <= ST_RESP;
                    end
                end
                ST_WR:   state <= ST_RESP;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.Ready          = (state == ST_IDLE);
        bus.Done           = (state == ST_RESP);
        bus.Error          = (state == ST_RESP) && err_q;
        bus.Mem_Address    = (state == ST_RD || state == ST_WR) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        bus.Mem_WE         = (state == ST_WR) && !Rst;
        bus.Mem_Write_Data = (state == ST_WR) ? merged : '0;
    end

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Load_Count  <= '0;
            Store_Count <= '0;
        end else if (state == ST_RESP && !err_q) begin
            if (is_store_q)
                Store_Count <= Store_Count + 32'd1;
            else
                Load_Count <= Load_Count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized self-checking bench for lsu_mem_ctrl against a byte-array memory model.
module tb_lsu_mem_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.ADDR_W(32)) bus ();

`ifdef LSU_PERF_CNT_EN
    logic [31:0] load_count;
    logic [31:0] store_count;
`endif

    lsu_mem_ctrl #(.ADDR_W(32), .MEM_BYTES(512)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
`ifdef LSU_PERF_CNT_EN
        ,
        .Load_Count  (load_count),
        .Store_Count (store_count)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Physical memory: word array, async read, write on clock edge.
    logic [31:0] mem [128];
    logic        fill_en = 1'b0;
    logic [6:0]  fill_idx;
    logic [31:0] fill_val;
    assign bus.Mem_Read_Data = mem[bus.Mem_Address[8:2]];
    always @(posedge clk) begin
        if (fill_en)
            mem[fill_idx] <= fill_val;
        else if (bus.Mem_WE)
            mem[bus.Mem_Address[8:2]] <= bus.Mem_Write_Data;
    end

    int          we_cnt = 0;
    logic [31:0] we_addr;
    logic [31:0] we_data;
    always @(negedge clk) begin
        if (bus.Mem_WE === 1'b1) begin
            we_cnt++;
            we_addr = bus.Mem_Address;
            we_data = bus.Mem_Write_Data;
        end
    end

    // Reference model: byte-addressed memory plus expected visible state.
    logic [7:0]  rb [512];
    logic [31:0] exp_load = '0;
    int          exp_lc = 0;
    int          exp_sc = 0;

    function automatic logic [31:0] ref_word(input int a);
        return {rb[a+3], rb[a+2], rb[a+1], rb[a]};
    endfunction

    function automatic int op_size(input int f3);
        return (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    endfunction

    function automatic bit ref_legal(input bit st, input int f3, input logic [31:0] a);
        bit ok;
        ok = st ? (f3 <= 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        return ok && (a % op_size(f3) == 0) && (a < 512);
    endfunction

    task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int n;
        int w0;
        int sz;
        bit lg;
        int exp_lat;
        logic [31:0] val;
        @(negedge clk);
        check_val({tag, "_ready"}, {31'd0, bus.Ready}, 32'd1);
        bus.Req = 1'b1;
        bus.Is_Store = st;
        bus.Funct3 = f3;
        bus.Addr = a;
        bus.Store_Data = d;
        w0 = we_cnt;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.Done !== 1'b1 && n < 8);
        lg = ref_legal(st, int'(f3), a);
        sz = op_size(int'(f3));
        exp_lat = !lg ? 1 : (!st || f3 == 3'd2) ? 2 : 3;
        check_val({tag, "_latency"}, n, exp_lat);
        check_val({tag, "_error"}, {31'd0, bus.Error}, {31'd0, !lg});
        if (lg && !st) begin
            val = '0;
            for (int i = 0; i < sz; i++)
                val = val | (32'(rb[int'(a) + i]) << (8 * i));
            if (f3 == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
            if (f3 == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
            exp_load = val;
            exp_lc++;
        end
        if (lg && st) begin
            for (int i = 0; i < sz; i++)
                rb[int'(a) + i] = d[8*i +: 8];
            exp_sc++;
        end
        check_val({tag, "_load_data"}, bus.Load_Data, exp_load);
        check_val({tag, "_we_pulses"}, we_cnt - w0, (lg && st) ? 1 : 0);
        if (lg && st) begin
            check_val({tag, "_we_addr"}, we_addr, a & 32'hFFFF_FFFC);
            check_val({tag, "_we_data"}, we_data, ref_word(int'(a & 32'hFFFF_FFFC)));
        end
        bus.Req = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        int w0;
        rst = 1'b1;
        bus.Req = 1'b0;
        bus.Is_Store = 1'b0;
        bus.Funct3 = '0;
        bus.Addr = '0;
        bus.Store_Data = '0;

        fill_en = 1'b1;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            w = $urandom;
            fill_idx = 7'(i);
            fill_val = w;
            for (int b = 0; b < 4; b++)
                rb[4*i + b] = w[8*b +: 8];
        end
        @(negedge clk);
        fill_en = 1'b0;
        @(negedge clk);
        check_val("rst_ready", {31'd0, bus.Ready}, 32'd1);
        check_val("rst_done", {31'd0, bus.Done}, 32'd0);
        check_val("rst_error", {31'd0, bus.Error}, 32'd0);
        check_val("rst_load_data", bus.Load_Data, 32'd0);
        check_val("rst_mem_addr", bus.Mem_Address, 32'd0);
        check_val("rst_mem_wdata", bus.Mem_Write_Data, 32'd0);
        check_val("rst_mem_we", {31'd0, bus.Mem_WE}, 32'd0);
        rst = 1'b0;

        run_op(1'b1, 3'd2, 32'h10, 32'h8899AABB, "sw_setup");
        run_op(1'b0, 3'd2, 32'h10, 32'h0, "lw_10");
        check_val("lw_10_const", bus.Load_Data, 32'h8899AABB);
        run_op(1'b1, 3'd2, 32'h10, 32'h80112233, "sw_setup2");
        run_op(1'b0, 3'd0, 32'h13, 32'h0, "lb_13");
        check_val("lb_13_const", bus.Load_Data, 32'hFFFFFF80);
        run_op(1'b0, 3'd4, 32'h13, 32'h0, "lbu_13");
        check_val("lbu_13_const", bus.Load_Data, 32'h00000080);
        run_op(1'b1, 3'd2, 32'h20, 32'h11223344, "sw_setup3");
        run_op(1'b1, 3'd0, 32'h22, 32'h000000CC, "sb_22");
        check_val("sb_22_const", we_data, 32'h11CC3344);
        run_op(1'b0, 3'd1, 32'h05, 32'h0, "lh_misaligned");
        run_op(1'b1, 3'd2, 32'h1FE, 32'h12345678, "sw_misaligned");
        run_op(1'b0, 3'd2, 32'h200, 32'h0, "lw_range");
        run_op(1'b0, 3'd3, 32'h40, 32'h0, "ld_bad_f3");
        run_op(1'b1, 3'd4, 32'h40, 32'h55, "st_bad_f3");
        run_op(1'b0, 3'd5, 32'h1FE, 32'h0, "lhu_top");

        // Reset while the SH sits in its write cycle.
        @(negedge clk);
        bus.Req = 1'b1;
        bus.Is_Store = 1'b1;
        bus.Funct3 = 3'd1;
        bus.Addr = 32'h42;
        bus.Store_Data = 32'h0000BEEF;
        w0 = we_cnt;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.Req = 1'b0;
        @(negedge clk);
        check_val("rstwr_we_gated", {31'd0, bus.Mem_WE}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_val("rstwr_ready", {31'd0, bus.Ready}, 32'd1);
        check_val("rstwr_done", {31'd0, bus.Done}, 32'd0);
        check_val("rstwr_load_data", bus.Load_Data, 32'd0);
        check_val("rstwr_mem_addr", bus.Mem_Address, 32'd0);
        check_val("rstwr_mem_wdata", bus.Mem_Write_Data, 32'd0);
        @(negedge clk);
        check_val("rstwr_no_done", {31'd0, bus.Done}, 32'd0);
        check_val("rstwr_no_write", we_cnt - w0, 32'd0);
        exp_load = '0;
        exp_lc = 0;
        exp_sc = 0;
        run_op(1'b0, 3'd2, 32'h40, 32'h0, "lw_after_rst");

        for (int k = 0; k < 80; k++) begin
            bit st;
            logic [2:0] f3;
            logic [31:0] a;
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                f3 = 3'($urandom_range(0, 7));
            else if (st)
                f3 = 3'($urandom_range(0, 2));
            else
                f3 = (k % 5 == 3) ? 3'd4 : (k % 5 == 4) ? 3'd5 : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0)
                a = 32'($urandom_range(512, 1023));
            else
                a = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0)
                a = a & ~32'(op_size(int'(f3)) - 1);
            run_op(st, f3, a, $urandom, "rand");
        end

`ifdef LSU_PERF_CNT_EN
        @(negedge clk);
        check_val("load_count", load_count, exp_lc);
        check_val("store_count", store_count, exp_sc);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
